// File: rtl/reg_file_mp.sv
// Multi-port register file: two prioritised write ports, NREAD combinational read ports,
// optional write-to-read bypass and a sequenced bulk-clear engine. Optional macro: REG_FILE_ZERO_REG_EN.
module reg_file_mp #(
    parameter int WORDSIZE  = 24,
    parameter int BLOCKSIZE = 64,
    parameter int NREAD     = 2,
    parameter int BYPASS    = 1,
    localparam int ADR      = $clog2(BLOCKSIZE)
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic                      WE0,
    input  logic [ADR-1:0]            AW0,
    input  logic [WORDSIZE-1:0]       D0,
    input  logic                      WE1,
    input  logic [ADR-1:0]            AW1,
    input  logic [WORDSIZE-1:0]       D1,
    input  logic [NREAD*ADR-1:0]      AR,
    output logic [NREAD*WORDSIZE-1:0] Q,
    input  logic                      CLR,
    output logic                      BUSY,
    output logic                      dbg_state
);

    typedef enum logic {IDLE, CLEARING} state_t;

    state_t              state, state_next;
    logic [ADR-1:0]      ptr;
    logic                wr0_ok, wr1_ok, last_entry;
    logic [WORDSIZE-1:0] mem [BLOCKSIZE];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state <= IDLE;
        else       state <= state_next;
    end

    assign last_entry = (ptr == ADR'(BLOCKSIZE - 1));

    always_comb begin
        state_next = state;
        BUSY       = 1'b0;
        // RSTN gating keeps bypass from forwarding while reset holds Q at zero.
        wr0_ok     = WE0 && RSTN && (state == IDLE);
        wr1_ok     = WE1 && RSTN && (state == IDLE);
`ifdef REG_FILE_ZERO_REG_EN
        if (AW0 == '0) wr0_ok = 1'b0;
        if (AW1 == '0) wr1_ok = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (CLR) state_next = CLEARING;
            end
            CLEARING: begin
                BUSY = 1'b1;
                if (last_entry) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dbg_state = (state == CLEARING);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ptr <= '0;
            for (int i = 0; i < BLOCKSIZE; i++) mem[i] <= '0;
        end else if (state == CLEARING) begin
            mem[ptr] <= '0;
            ptr      <= ptr + 1'b1;
        end else begin
            ptr <= '0;
            // Port 1 wins an address collision, so port 0 is suppressed explicitly.
            if (wr0_ok && !(wr1_ok && (AW1 == AW0))) mem[AW0] <= D0;
            if (wr1_ok) mem[AW1] <= D1;
        end
    end

    always_comb begin
        Q = '0;
        for (int i = 0; i < NREAD; i++) begin
            Q[i*WORDSIZE +: WORDSIZE] = mem[AR[i*ADR +: ADR]];
            if (BYPASS != 0) begin
                if (wr1_ok && (AW1 == AR[i*ADR +: ADR]))
                    Q[i*WORDSIZE +: WORDSIZE] = D1;
                else if (wr0_ok && (AW0 == AR[i*ADR +: ADR]))
                    Q[i*WORDSIZE +: WORDSIZE] = D0;
            end
`ifdef REG_FILE_ZERO_REG_EN
            if (AR[i*ADR +: ADR] == '0) Q[i*WORDSIZE +: WORDSIZE] = '0;
`endif
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed steps plus randomized traffic against an
// array-based reference model of the register file and its clear countdown.
module tb_reg_file_mp;
    localparam int W  = 24;
    localparam int S  = 64;
    localparam int NR = 2;
    localparam int A  = 6;
`ifdef REG_FILE_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RSTN, WE0, WE1, CLR;
    logic [A-1:0]  AW0, AW1;
    logic [W-1:0]  D0, D1;
    logic [NR*A-1:0] AR;
    logic [NR*W-1:0] Q;
    logic          BUSY, dbg_state;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] ref_mem [S];
    int clr_left = 0;
    int busy_cycles;

    always #5 CLK = ~CLK;

    reg_file_mp #(.WORDSIZE(W), .BLOCKSIZE(S), .NREAD(NR), .BYPASS(1)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .WE0(WE0), .AW0(AW0), .D0(D0),
        .WE1(WE1), .AW1(AW1), .D1(D1),
        .AR(AR), .Q(Q), .CLR(CLR), .BUSY(BUSY), .dbg_state(dbg_state)
    );

    function automatic bit wr_ok(input logic we, input logic [A-1:0] aw);
        return we && RSTN && (clr_left == 0) && !(ZERO && aw == 0);
    endfunction

    function automatic logic [W-1:0] ref_read(input logic [A-1:0] a);
        if (ZERO && a == 0) return '0;
        if (wr_ok(WE1, AW1) && AW1 == a) return D1;
        if (wr_ok(WE0, AW0) && AW0 == a) return D0;
        return ref_mem[a];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NR; i++)
            check($sformatf("%s_q%0d", tag, i), Q[i*W +: W], ref_read(AR[i*A +: A]));
        check({tag, "_busy"}, W'(BUSY), W'(clr_left > 0));
        check({tag, "_state"}, W'(dbg_state), W'(clr_left > 0));
    endtask

    task automatic drive(input logic we0, input logic [A-1:0] aw0, input logic [W-1:0] d0,
                         input logic we1, input logic [A-1:0] aw1, input logic [W-1:0] d1,
                         input logic clr);
        @(negedge CLK);
        WE0 = we0; AW0 = aw0; D0 = d0;
        WE1 = we1; AW1 = aw1; D1 = d1;
        CLR = clr;
        #1;
    endtask

    // Model update uses the inputs held stable across the coming edge.
    task automatic tick();
        if (clr_left > 0) begin
            ref_mem[S - clr_left] = '0;
            clr_left--;
        end else begin
            if (wr_ok(WE0, AW0)) ref_mem[AW0] = D0;
            if (wr_ok(WE1, AW1)) ref_mem[AW1] = D1;
            if (CLR) clr_left = S;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < S; i++) ref_mem[i] = '0;
        clr_left = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTN = 1'b0; WE0 = 0; WE1 = 0; CLR = 0; AW0 = 0; AW1 = 0; D0 = 0; D1 = 0;
        AR = {6'd25, 6'd24};
        model_reset();
        #12;
        check("rst_q0", Q[0 +: W], 24'd0);
        check("rst_q1", Q[W +: W], 24'd0);
        check("rst_busy", W'(BUSY), 24'd0);
        @(negedge CLK);
        RSTN = 1'b1;

        // Single writes, bypass ahead of the edge, readback after it.
        drive(1'b1, 6'd24, 24'd8596, 1'b0, '0, '0, 1'b0);
        check("bypass_q0", Q[0 +: W], 24'd8596);
        check_all("wr24_pre");
        tick();
        idle();
        check("wr24", Q[0 +: W], 24'd8596);
        drive(1'b1, 6'd25, 24'd72145, 1'b0, '0, '0, 1'b0);
        tick();
        idle();
        check("wr25", Q[W +: W], 24'd72145);
        AR[0 +: A] = 6'd10; #1;
        check("rd10", Q[0 +: W], 24'd0);
        AR[0 +: A] = 6'd24; #1;
        check("rd24_again", Q[0 +: W], 24'd8596);

        // Collision and distinct dual writes.
        drive(1'b1, 6'd5, 24'h111111, 1'b1, 6'd5, 24'h222222, 1'b0);
        AR = {6'd5, 6'd5}; #1;
        check("coll_bypass", Q[0 +: W], 24'h222222);
        tick();
        idle();
        check("coll", Q[0 +: W], 24'h222222);
        drive(1'b1, 6'd6, 24'h0a0a0a, 1'b1, 6'd7, 24'h0b0b0b, 1'b0);
        tick();
        idle();
        AR = {6'd7, 6'd6}; #1;
        check("dual6", Q[0 +: W], 24'h0a0a0a);
        check("dual7", Q[W +: W], 24'h0b0b0b);

        // Entry 0: ordinary register unless hardwired to zero.
        drive(1'b1, 6'd0, 24'h123456, 1'b0, '0, '0, 1'b0);
        AR = {6'd0, 6'd0}; #1;
        check_all("zero_pre");
        tick();
        idle();
        check("zero_rd", Q[0 +: W], ZERO ? 24'd0 : 24'h123456);

        // Randomized traffic with occasional clears.
        repeat (400) begin
            @(negedge CLK);
            WE0 = 1'($urandom_range(0, 1));
            WE1 = 1'($urandom_range(0, 1));
            AW0 = ($urandom_range(0, 1) != 0) ? A'($urandom_range(0, 7)) : A'($urandom);
            AW1 = ($urandom_range(0, 1) != 0) ? A'($urandom_range(0, 7)) : A'($urandom);
            D0  = W'($urandom);
            D1  = W'($urandom);
            CLR = ($urandom_range(0, 79) == 0);
            for (int i = 0; i < NR; i++)
                AR[i*A +: A] = ($urandom_range(0, 1) != 0) ? A'($urandom_range(0, 7)) : A'($urandom);
            #1;
            check_all("rnd_pre");
            tick();
            check_all("rnd_post");
        end
        while (clr_left > 0) begin
            idle();
            tick();
        end

        // Fill with index+1, then run a full clear sequence.
        for (int i = 0; i < S / 2; i++) begin
            drive(1'b1, A'(2 * i), W'(2 * i + 1), 1'b1, A'(2 * i + 1), W'(2 * i + 2), 1'b0);
            tick();
        end
        AR = {6'd63, 6'd10};
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        check("fill10", Q[0 +: W], 24'd11);
        check("fill63", Q[W +: W], 24'd64);
        tick();
        busy_cycles = 0;
        for (int c = 0; c < 200 && BUSY; c++) begin
            busy_cycles++;
            if (c == 5)       drive(1'b1, 6'd63, 24'h00dead, 1'b0, '0, '0, 1'b0);
            else if (c == 30) drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
            else              idle();
            check("clr_e10", Q[0 +: W], (c >= 11) ? 24'd0 : 24'd11);
            check_all("clr");
            tick();
        end
        check("busy_cycles", W'(busy_cycles), W'(S));
        idle();
        check("clr_e63", Q[W +: W], 24'd0);
        check_all("clr_done");

        // Reset in the middle of a clear sequence.
        for (int i = 0; i < S; i++) begin
            if (i % 2 == 0) begin
                drive(1'b1, A'(i), W'($urandom_range(1, 1000)), 1'b0, '0, '0, 1'b0);
                tick();
            end
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        tick();
        idle();
        repeat (30) tick();
        check("midclr_busy", W'(BUSY), 24'd1);
        @(negedge CLK);
        RSTN = 1'b0;
        #1;
        model_reset();
        check("midrst_busy", W'(BUSY), 24'd0);
        for (int a = 0; a < S; a += 2) begin
            AR = {A'(a + 1), A'(a)};
            #1;
            check("midrst_q0", Q[0 +: W], 24'd0);
            check("midrst_q1", Q[W +: W], 24'd0);
        end
        @(negedge CLK);
        RSTN = 1'b1;
        idle();
        check_all("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
